// File: rtl/quiz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quiz_pkg
//  Description : Shared constants for the quiz vector checker: FSM state
//                encoding, vector count and datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package quiz_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int STEP_W      = 8;

    // Checker FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_PASS   = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

endpackage : quiz_pkg
`default_nettype wire

// File: rtl/quiz_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : quiz_settle_timer
//  Description : 8-bit down-counter with synchronous load, decrement enable
//                and zero flag. Counting stops at zero.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active high
//                i_load     - load i_load_val (has priority over i_en)
//                i_load_val - value to load
//                i_en       - decrement by one when non-zero
//                o_zero     - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module quiz_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_en,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule : quiz_settle_timer
`default_nettype wire

// File: rtl/quiz_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : quiz_vector_checker
//  Description : Drives all 8 {s,b,a} combinations into a 3-input unit under
//                test, holds each for SETTLE_CYCLES edges, samples y for one
//                cycle and compares it with EXPECTED[idx]. Reports a match
//                count and a sticky pass/fail verdict.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous reset, active high
//                start    - begin a run (honoured in IDLE, PASS, FAIL only)
//                a, b, s  - stimulus, {s,b,a} = current vector index
//                y        - combinational response of the unit under test
//                busy     - run in progress
//                done     - verdict available
//                pass     - all vectors matched
//                fail     - a vector mismatched
//                step     - vectors matched in the current run
//                fail_idx - index of the first mismatching vector
//  Revision    : 1.0 - initial release
// ============================================================================
module quiz_vector_checker
    import quiz_pkg::*;
#(
    parameter logic [7:0] EXPECTED      = 8'h99,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              a,
    output logic              b,
    output logic              s,
    input  logic              y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [STEP_W-1:0] step,
    output logic [IDX_W-1:0]  fail_idx
);

    localparam logic [7:0]       C_RELOAD   = 8'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [STEP_W-1:0] r_step;
    logic [IDX_W-1:0]  r_fail_idx;

    logic w_launch;
    logic w_match;
    logic w_advance;
    logic w_timer_load;
    logic w_timer_en;
    logic w_timer_zero;

    // A new run may only be launched from a resting state
    assign w_launch  = start && ((r_state == ST_IDLE) ||
                                 (r_state == ST_PASS) ||
                                 (r_state == ST_FAIL));
    assign w_match   = (y == EXPECTED[r_idx]);
    // CHECK succeeded and there is another vector to apply
    assign w_advance = (r_state == ST_CHECK) && w_match && (r_idx != C_LAST_IDX);

    quiz_settle_timer u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_timer_load),
        .i_load_val (C_RELOAD),
        .i_en       (w_timer_en),
        .o_zero     (w_timer_zero)
    );

    // ---------------- State register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_timer_zero) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (!w_match)                 w_next_state = ST_FAIL;
                else if (r_idx == C_LAST_IDX) w_next_state = ST_PASS;
                else                          w_next_state = ST_SETTLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- Output / control decode ----------------
    always_comb begin
        busy         = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
        done         = (r_state == ST_PASS)   || (r_state == ST_FAIL);
        pass         = (r_state == ST_PASS);
        fail         = (r_state == ST_FAIL);
        w_timer_load = w_launch || w_advance;
        w_timer_en   = (r_state == ST_SETTLE);
    end

    // ---------------- Vector index and result registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_step     <= '0;
            r_fail_idx <= '0;
        end else if (w_launch) begin
            r_idx      <= '0;
            r_step     <= '0;
            r_fail_idx <= '0;
        end else if (r_state == ST_CHECK) begin
            if (!w_match) begin
                r_fail_idx <= r_idx;
            end else begin
                r_step <= r_step + 1'b1;
                // idx stays at 7 after the last vector so a,b,s keep it
                if (r_idx != C_LAST_IDX) r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign a        = r_idx[0];
    assign b        = r_idx[1];
    assign s        = r_idx[2];
    assign step     = r_step;
    assign fail_idx = r_fail_idx;

endmodule : quiz_vector_checker
`default_nettype wire

// File: tb/tb_quiz_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quiz_vector_checker
//  Description : Scoreboard bench for quiz_vector_checker. Expected verdicts
//                are queued at each start pulse and popped by a monitor on
//                every rising edge of done. A second instance with
//                SETTLE_CYCLES=1 exercises back-to-back runs with start held.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quiz_vector_checker;

    typedef struct {
        logic       pass;
        logic       fail;
        logic [7:0] step;
        logic [2:0] fidx;
        logic [2:0] vec;
        int         lat;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       y;
    wire        a, b, s, busy, done, pass, fail;
    wire  [7:0] step;
    wire  [2:0] fail_idx;

    logic       start1 = 1'b0;
    logic       y1;
    wire        a1, b1, s1, busy1, done1, pass1, fail1;
    wire  [7:0] step1;
    wire  [2:0] fail_idx1;

    int   mode = 0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   t_start = 0;
    logic done_q = 1'b0;
    exp_t q[$];

    quiz_vector_checker #(.EXPECTED(8'h99), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a(a), .b(b), .s(s), .y(y),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .step(step), .fail_idx(fail_idx)
    );

    quiz_vector_checker #(.EXPECTED(8'h99), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .a(a1), .b(b1), .s(s1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
        .step(step1), .fail_idx(fail_idx1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Models of the unit under test
    always_comb begin
        y = 1'b0;
        case (mode)
            0: y = ~(a ^ b);
            1: y = a & b;
            2: y = ~(a ^ b) ^ s;
            default: y = 1'b1;
        endcase
    end
    assign y1 = ~(a1 ^ b1);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every verdict must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done && !done_q) begin
            if (q.size() == 0) begin
                chk("unexpected_verdict", done, 0);
            end else begin
                e = q.pop_front();
                chk("pass",     pass,         e.pass);
                chk("fail",     fail,         e.fail);
                chk("step",     step,         e.step);
                chk("fail_idx", fail_idx,     e.fidx);
                chk("vector",   {s, b, a},    e.vec);
                chk("latency",  cyc - t_start, e.lat);
            end
        end
        done_q <= done;
    end

    task automatic launch(input logic push, input exp_t e);
        @(negedge clk);
        start   = 1'b1;
        t_start = cyc + 1;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, done, 1);
    endtask

    function automatic exp_t mk(input logic p, input logic f, input int st,
                                input int fi, input int v, input int l);
        exp_t e;
        e.pass = p; e.fail = f; e.step = 8'(st);
        e.fidx = 3'(fi); e.vec = 3'(v); e.lat = l;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_step", step, 0);
        chk("rst_fidx", fail_idx, 0);
        chk("rst_vec",  {s, b, a}, 0);
        reset = 1'b0;

        // Correct unit; a start pulse mid-run must be ignored
        mode = 0;
        launch(1'b1, mk(1, 0, 8, 0, 7, 24));
        chk("busy_after_start", busy, 1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("pass_run");

        // y = a & b fails on vector 0
        mode = 1;
        launch(1'b1, mk(0, 1, 0, 0, 0, 3));
        wait_done("and_run");

        // y depends on s: vectors 0..3 match, 4 mismatches
        mode = 2;
        launch(1'b1, mk(0, 1, 4, 4, 4, 15));
        wait_done("xnor_s_run");

        // y stuck at 1, then restart from FAIL
        mode = 3;
        launch(1'b1, mk(0, 1, 1, 1, 1, 6));
        wait_done("stuck1_run");
        launch(1'b1, mk(0, 1, 1, 1, 1, 6));
        chk("restart_fail_clr", fail, 0);
        chk("restart_busy", busy, 1);
        wait_done("stuck1_rerun");

        // Asynchronous reset in the middle of a run: no verdict expected
        mode = 0;
        launch(1'b0, mk(0, 0, 0, 0, 0, 0));
        repeat (9) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_step", step, 0);
        chk("arst_vec",  {s, b, a}, 0);
        @(negedge clk);
        reset = 1'b0;
        launch(1'b1, mk(1, 0, 8, 0, 7, 24));
        wait_done("post_rst_run");
        @(negedge clk);

        // SETTLE_CYCLES=1 instance with start held high
        begin
            int   rises[3];
            int   nr = 0;
            int   t0;
            logic prev = 1'b0;
            @(negedge clk);
            start1 = 1'b1;
            t0     = cyc + 1;
            for (int k = 0; k < 80 && nr < 3; k++) begin
                @(negedge clk);
                if (pass1 && !prev) begin
                    rises[nr] = cyc;
                    nr++;
                    chk("b2b_step", step1, 8);
                end else if (prev) begin
                    chk("b2b_pass_one_cycle", pass1, 0);
                    chk("b2b_restart_busy", busy1, 1);
                end
                prev = pass1;
            end
            start1 = 1'b0;
            chk("b2b_runs", nr, 3);
            if (nr == 3) begin
                chk("b2b_lat0",   rises[0] - t0, 16);
                chk("b2b_period", rises[1] - rises[0], 17);
                chk("b2b_period", rises[2] - rises[1], 17);
            end
        end

        repeat (2) @(negedge clk);
        chk("pending_expectations", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_quiz_vector_checker
`default_nettype wire

// File: doc/quiz_vector_checker.md
Name: quiz_vector_checker

Overview:
- Hardware stimulus/checker stage that sits directly upstream of the 3-input quiz logic unit (inputs s, a, b; output y).
- Walks all 8 input combinations, waits a settle time on each, samples y, and compares it with an expected truth table.
- Reports progress as a step count and a sticky pass or fail verdict.
- Lets quiz answers be checked on-chip rather than only by a simulation bench.

Parameters:
- EXPECTED, 8'h99: expected y for each vector index idx = {s,b,a}. Bit idx holds y for that vector. Default encodes y = ~(a^b), independent of s.
- SETTLE_CYCLES, 2: clock edges each vector is held before y is sampled. Legal range 1..255.

Ports:
- clk, input, 1: clock, rising-edge active.
- reset, input, 1: asynchronous reset, active-high.
- start, input, 1: begin a run. Sampled only in IDLE, PASS or FAIL.
- a, output, 1: stimulus to the unit under test, idx[0].
- b, output, 1: stimulus to the unit under test, idx[1].
- s, output, 1: stimulus to the unit under test, idx[2].
- y, input, 1: response from the unit under test (combinational).
- busy, output, 1: high while in SETTLE or CHECK.
- done, output, 1: high in PASS or FAIL.
- pass, output, 1: high only in PASS.
- fail, output, 1: high only in FAIL.
- step, output, 8: count of vectors that matched in the current run.
- fail_idx, output, 3: idx of the first mismatching vector. Valid when fail=1.

Behaviour:
- Reset (async, any state): state=IDLE. a, b, s, busy, done, pass, fail, step, fail_idx all 0. Settle counter=0.
- States: IDLE, SETTLE, CHECK, PASS, FAIL. All outputs are registered or decoded from state and idx only.
- IDLE/PASS/FAIL with start=1 at an edge:
  - next state SETTLE, idx←0, step←0, fail_idx←0, counter←SETTLE_CYCLES-1.
  - pass and fail clear on that same edge.
- SETTLE: {s,b,a}=idx is held stable. Each edge decrements the counter. An edge with counter==0 moves to CHECK.
- CHECK (one cycle): y is compared against EXPECTED[idx] at the edge.
  - Mismatch → FAIL, fail_idx←idx, step unchanged.
  - Match and idx==7 → PASS, step←step+1 (final value 8).
  - Match and idx<7 → SETTLE, idx←idx+1, step←step+1, counter reloaded with SETTLE_CYCLES-1.
- Each vector takes SETTLE_CYCLES+1 edges. A full passing run takes 8*(SETTLE_CYCLES+1) edges from the start edge; default is 24.
- PASS and FAIL are sticky until reset or a new start. a, b, s keep the last applied vector.
- start while busy is ignored. start held high continuously restarts immediately after each verdict.
- idx does not wrap: 7 is terminal, and there is no step 9.
- y is sampled only in CHECK. Glitches during SETTLE are ignored.
- Reset mid-run: immediate return to IDLE. No verdict is produced. The next start runs a full sequence from idx 0.

Decomposition:
- Shared package quiz_pkg:
  - state encoding constants (IDLE=0, SETTLE=1, CHECK=2, PASS=3, FAIL=4; 3-bit)
  - NUM_VECTORS=8
  - IDX_W=3
  - STEP_W=8
- One sub-module, quiz_settle_timer: 8-bit down-counter with load, enable, and zero flag, async reset. The top-level FSM instantiates it once.

Test Plan:
- DUT y=~(a^b), SETTLE=2, 1-cycle start pulse → busy high for 24 cycles, then pass=1, done=1, fail=0, step=8, {s,b,a}=3'b111.
- DUT y=a&b → mismatch at vector 000 (expects 1) → fail=1, fail_idx=0, step=0, busy low 3 cycles after start.
- DUT y=~(a^b)^s → vectors 0..3 match, vector 4 mismatches → fail=1, fail_idx=4, step=4.
- DUT y stuck at 1 → fail_idx=1, step=1; a restart pulse from FAIL clears fail and fails again identically.
- Correct DUT, reset asserted for 1 cycle at cycle 10 of a run → all outputs 0 asynchronously, state IDLE; a new start gives pass=1, step=8 after 24 cycles.
- SETTLE=1 and start held high throughout → each run takes 16 cycles; pass=1 for exactly 1 cycle between back-to-back runs; start is ignored while busy.
